// File: rtl/exe_mem_stage.sv
// EXE/MEM pipeline register with valid/ready handshake, flush and status flags.
// Bubbles carry no side effects: control outputs are cleared whenever the entry drains.
module exe_mem_stage #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              s_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [3:0]        nzcv_in,
    output logic              out_valid,
    input  logic              mem_ready,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] val_rm,
    output logic [DEST_W-1:0] dest,
    output logic [3:0]        status
);

    logic accept;
    logic drain;

    assign in_ready = (!out_valid || mem_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign drain    = flush || (out_valid && mem_ready);

    // Flush is already excluded from accept through in_ready, so it dominates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            wb_en     <= 1'b0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            alu_res   <= '0;
            val_rm    <= '0;
            dest      <= '0;
            status    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            wb_en     <= wb_en_in;
            mem_r_en  <= mem_r_en_in;
            mem_w_en  <= mem_w_en_in;
            alu_res   <= alu_res_in;
            val_rm    <= val_rm_in;
            dest      <= dest_in;
            if (s_in) begin
                status <= nzcv_in;
            end
        end else if (drain) begin
            out_valid <= 1'b0;
            wb_en     <= 1'b0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed bench for exe_mem_stage: reset, pass-through, stall, status, flush, bubble.
module tb_exe_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in;
    logic [31:0] alu_res_in, val_rm_in;
    logic [3:0]  dest_in, nzcv_in;
    logic        out_valid, mem_ready;
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_res, val_rm;
    logic [3:0]  dest, status;

    int errors = 0;
    int checks = 0;

    exe_mem_stage #(.DATA_W(32), .DEST_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .s_in(s_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .nzcv_in(nzcv_in), .out_valid(out_valid), .mem_ready(mem_ready),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .status(status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr, input logic mw,
                         input logic s, input logic [31:0] alu, input logic [31:0] rm,
                         input logic [3:0] d, input logic [3:0] f);
        in_valid = v; wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw;
        s_in = s; alu_res_in = alu; val_rm_in = rm; dest_in = d; nzcv_in = f;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_status", {28'd0, status}, 32'd0);
        #13 rst = 1'b1;

        // Load an entry with status 1010, then assert reset between edges
        drive(1, 1, 0, 1, 1, 32'h55, 32'h66, 4'h7, 4'b1010);
        step();
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_status", {28'd0, status}, 32'hA);
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        #2 rst = 1'b0;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_status", {28'd0, status}, 32'd0);
        check("async_ctrl", {29'd0, wb_en, mem_r_en, mem_w_en}, 32'd0);
        check("async_alu_res", alu_res, 32'd0);
        check("async_val_rm", val_rm, 32'd0);
        check("async_dest", {28'd0, dest}, 32'd0);
        check("async_in_ready", {31'd0, in_ready}, 32'd1);
        #1 rst = 1'b1;

        // Pass-through
        mem_ready = 1'b1;
        drive(1, 1, 0, 0, 0, 32'h10, 32'h0, 4'h3, 4'h0);
        #1 check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("pt_out_valid", {31'd0, out_valid}, 32'd1);
        check("pt_alu_res", alu_res, 32'h10);
        check("pt_dest", {28'd0, dest}, 32'd3);
        check("pt_wb_en", {31'd0, wb_en}, 32'd1);

        // Stall: LDR held while MEM not ready
        drive(1, 1, 1, 0, 0, 32'h400, 32'h0, 4'h5, 4'h0);
        step();
        check("ldr_mem_r_en", {31'd0, mem_r_en}, 32'd1);
        mem_ready = 1'b0;
        drive(1, 1, 0, 0, 0, 32'h500, 32'h9, 4'h6, 4'h0);
        #1 check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_alu_res", alu_res, 32'h400);
            check("stall_mem_r_en", {31'd0, mem_r_en}, 32'd1);
            check("stall_dest", {28'd0, dest}, 32'd5);
            check("stall_val_rm", val_rm, 32'h0);
        end
        mem_ready = 1'b1;
        #1 check("unstall_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("unstall_alu_res", alu_res, 32'h500);
        check("unstall_dest", {28'd0, dest}, 32'd6);
        check("unstall_mem_r_en", {31'd0, mem_r_en}, 32'd0);
        check("unstall_wb_en", {31'd0, wb_en}, 32'd1);

        // Status update only with s_in
        drive(1, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0, 4'b0110);
        step();
        check("cmp_status", {28'd0, status}, 32'h6);
        drive(1, 1, 0, 0, 0, 32'h20, 32'h0, 4'h1, 4'b1000);
        step();
        check("add_status", {28'd0, status}, 32'h6);
        check("add_out_valid", {31'd0, out_valid}, 32'd1);

        // Flush dominates accept and mem_ready
        flush = 1'b1;
        drive(1, 1, 0, 1, 1, 32'h30, 32'h31, 4'h2, 4'b1111);
        #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_wb_en", {31'd0, wb_en}, 32'd0);
        check("flush_mem_w_en", {31'd0, mem_w_en}, 32'd0);
        check("flush_status", {28'd0, status}, 32'h6);

        // Bubble between two accepts; mem_ready while empty is a no-op
        step();
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        drive(1, 1, 0, 1, 0, 32'h40, 32'h41, 4'h8, 4'h0);
        step();
        check("bub_a_valid", {31'd0, out_valid}, 32'd1);
        check("bub_a_mem_w_en", {31'd0, mem_w_en}, 32'd1);
        drive(0, 1, 1, 1, 1, 32'hBAD, 32'hBAD, 4'hF, 4'hF);
        step();
        check("bub_valid", {31'd0, out_valid}, 32'd0);
        check("bub_ctrl", {29'd0, wb_en, mem_r_en, mem_w_en}, 32'd0);
        check("bub_status", {28'd0, status}, 32'h6);
        drive(1, 1, 0, 0, 0, 32'h50, 32'h51, 4'h9, 4'h0);
        step();
        check("bub_b_valid", {31'd0, out_valid}, 32'd1);
        check("bub_b_alu_res", alu_res, 32'h50);
        check("bub_b_wb_en", {31'd0, wb_en}, 32'd1);
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
